// File: rtl/lms_sequencer_if.sv
// Bundle between the LMS sequencer, the AC97 audio block and the shared
// LMS datapath (delay-line RAM, coefficient RAM, pipelined MAC).
interface lms_sequencer_if #(
   parameter int DW = 8,
   parameter int AW = 4
);
   logic                       ready;
   logic                       adapt_en;
   logic signed [DW-1:0]       d_sample;
   logic signed [DW-1:0]       x_sample;
   logic signed [2*DW+AW-1:0]  mac_result;
   logic [AW-1:0]              x_addr;
   logic                       x_we;
   logic [DW-1:0]              x_wdata;
   logic [AW-1:0]              c_addr;
   logic                       c_we;
   logic                       c_zero;
   logic                       mac_clr;
   logic                       mac_en;
   logic                       mac_sel;
   logic signed [DW-1:0]       mu_err;
   logic signed [DW-1:0]       out_sample;
   logic                       out_valid;
   logic                       busy;
   logic                       overrun;

   modport slave (
      input  ready, adapt_en, d_sample, x_sample, mac_result,
      output x_addr, x_we, x_wdata, c_addr, c_we, c_zero,
      output mac_clr, mac_en, mac_sel, mu_err, out_sample,
      output out_valid, busy, overrun
   );

   modport master (
      output ready, adapt_en, d_sample, x_sample, mac_result,
      input  x_addr, x_we, x_wdata, c_addr, c_we, c_zero,
      input  mac_clr, mac_en, mac_sel, mu_err, out_sample,
      input  out_valid, busy, overrun
   );
endinterface

// File: rtl/lms_sequencer.sv
// Per-sample LMS noise-canceller controller: delay-line write, FIR pass,
// error formation and optional coefficient-update pass over a shared MAC.
module lms_sequencer #(
   parameter int TAPS     = 16,
   parameter int AW       = 4,
   parameter int DW       = 8,
   parameter int MAC_LAT  = 2,
   parameter int MU_SHIFT = 4
) (
   input logic            clk,
   input logic            rst,
   lms_sequencer_if.slave bus
);
   localparam int MW = 2 * DW + AW;
   localparam logic signed [DW-1:0] DMAX = {1'b0, {(DW-1){1'b1}}};
   localparam logic signed [DW-1:0] DMIN = ~DMAX;
   localparam logic signed [MW-1:0] YMAX = {{(MW-DW){1'b0}}, DMAX};
   localparam logic signed [MW-1:0] YMIN = ~YMAX;

   typedef enum logic [3:0] {
      S_INIT_PEND, S_INIT, S_IDLE, S_SHIFT, S_FILTER,
      S_DRAIN, S_ERR, S_UPDATE, S_DONE
   } state_t;

   state_t               state, state_n;
   logic [AW-1:0]        k, k_n;
   logic [AW-1:0]        head;
   logic signed [DW-1:0] d_q, x_q, e_q, mu_q;
   logic signed [MW-1:0] acc_sh;
   logic signed [DW-1:0] y, e;
   logic [DW:0]          diff;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_INIT_PEND;
         k     <= '0;
         head  <= '0;
         d_q   <= '0;
         x_q   <= '0;
         e_q   <= '0;
         mu_q  <= '0;
      end else begin
         state <= state_n;
         k     <= k_n;
         if (state == S_IDLE && bus.ready) begin
            d_q <= bus.d_sample;
            x_q <= bus.x_sample;
         end
         if (state == S_SHIFT)
            head <= head - 1'b1;
         if (state == S_ERR) begin
            e_q  <= e;
            mu_q <= e >>> MU_SHIFT;
         end
      end
   end

   // y = sat(acc >>> (DW-1)); e = sat(d - y), overflow seen in the extra bit
   always_comb begin
      acc_sh = bus.mac_result >>> (DW - 1);
      y      = acc_sh[DW-1:0];
      if (acc_sh > YMAX)
         y = DMAX;
      else if (acc_sh < YMIN)
         y = DMIN;
      diff = {d_q[DW-1], d_q} - {y[DW-1], y};
      e    = diff[DW-1:0];
      if (diff[DW] != diff[DW-1])
         e = diff[DW] ? DMIN : DMAX;
   end

   always_comb begin
      state_n       = state;
      k_n           = k;
      bus.x_addr    = '0;
      bus.x_we      = 1'b0;
      bus.x_wdata   = '0;
      bus.c_addr    = '0;
      bus.c_we      = 1'b0;
      bus.c_zero    = 1'b0;
      bus.mac_clr   = 1'b0;
      bus.mac_en    = 1'b0;
      bus.mac_sel   = 1'b0;
      bus.out_valid = 1'b0;
      unique case (state)
         S_INIT_PEND: begin
            k_n     = '0;
            state_n = S_INIT;
         end
         S_INIT: begin
            bus.x_addr = k;
            bus.c_addr = k;
            bus.x_we   = 1'b1;
            bus.c_we   = 1'b1;
            bus.c_zero = 1'b1;
            k_n        = k + 1'b1;
            if (k == AW'(TAPS - 1))
               state_n = S_IDLE;
         end
         S_IDLE: begin
            if (bus.ready)
               state_n = S_SHIFT;
         end
         S_SHIFT: begin
            bus.x_addr  = head - 1'b1;
            bus.x_we    = 1'b1;
            bus.x_wdata = x_q;
            bus.mac_clr = 1'b1;
            k_n         = '0;
            state_n     = S_FILTER;
         end
         S_FILTER: begin
            bus.x_addr = head + k;
            bus.c_addr = k;
            bus.mac_en = 1'b1;
            k_n        = k + 1'b1;
            if (k == AW'(TAPS - 1)) begin
               k_n     = '0;
               state_n = S_DRAIN;
            end
         end
         S_DRAIN: begin
            k_n = k + 1'b1;
            if (k == AW'(MAC_LAT - 1)) begin
               k_n     = '0;
               state_n = S_ERR;
            end
         end
         S_ERR: begin
            k_n     = '0;
            state_n = bus.adapt_en ? S_UPDATE : S_DONE;
         end
         S_UPDATE: begin
            bus.x_addr  = head + k;
            bus.c_addr  = k;
            bus.c_we    = 1'b1;
            bus.mac_en  = 1'b1;
            bus.mac_sel = 1'b1;
            k_n         = k + 1'b1;
            if (k == AW'(TAPS - 1))
               state_n = S_DONE;
         end
         S_DONE: begin
            bus.out_valid = 1'b1;
            state_n       = S_IDLE;
         end
         default: state_n = S_INIT_PEND;
      endcase
   end

   assign bus.out_sample = e_q;
   assign bus.mu_err     = mu_q;
   assign bus.busy       = !rst && state != S_IDLE;
   assign bus.overrun    = !rst && bus.ready && state != S_IDLE;
endmodule

// File: doc/lms_sequencer.md
Name: lms_sequencer

Overview:
- Per-sample controller for the LMS noise canceller placed between the AC97 audio block and the shared LMS datapath (delay-line RAM, coefficient RAM, one pipelined MAC).
- On each `ready` strobe from the audio block it:
  - writes the new noise-reference sample into a circular delay line;
  - runs the FIR pass through the MAC;
  - forms the error (cleaned audio) from the primary sample;
  - if enabled, runs the coefficient-update pass.
- Clears both RAMs after reset and flags samples that arrive while it is busy.

Parameters:
- TAPS, 16, filter length (power of two).
- AW, 4, log2(TAPS); address width.
- DW, 8, sample and coefficient width (signed; coefficients Q1.(DW-1)).
- MAC_LAT, 2, MAC pipeline latency in cycles from `mac_en` to valid `mac_result`.
- MU_SHIFT, 4, step size mu = 2^-MU_SHIFT.

Ports:
- Clk  in  1  system clock (27 MHz).
- Reset  in  1  asynchronous, active-high reset.
- ready  in  1  one-cycle new-sample strobe from the audio block.
- adapt_en  in  1  enables the coefficient-update pass; sampled in ERR.
- d_sample  in  DW  primary sample (signal+noise), signed; valid with `ready`.
- x_sample  in  DW  noise reference sample, signed; valid with `ready`.
- mac_result  in  2*DW+AW  signed accumulator output from the MAC.
- x_addr  out  AW  delay-line RAM address.
- x_we  out  1  delay-line write enable.
- x_wdata  out  DW  delay-line write data.
- c_addr  out  AW  coefficient RAM address.
- c_we  out  1  coefficient write enable (MAC computes c + mu_err*x).
- c_zero  out  1  forces coefficient write data to 0 (INIT only).
- mac_clr  out  1  clears the MAC accumulator.
- mac_en  out  1  MAC accepts a product this cycle.
- mac_sel  out  1  MAC mode: 0 = FIR (x*c), 1 = update (mu_err*x).
- mu_err  out  DW  e >>> MU_SHIFT, arithmetic shift; held through UPDATE.
- out_sample  out  DW  error sample e (cleaned audio); held until the next DONE.
- out_valid  out  1  one-cycle pulse, asserted in DONE.
- busy  out  1  high in every state except IDLE.
- overrun  out  1  one-cycle pulse when `ready` arrives while busy.

Behaviour:
- **Reset:** while `Reset`=1, every output is 0, state is INIT_PEND, head=0, k=0, and the latches are cleared.
  - INIT_PEND moves to INIT on the first clock edge after `Reset` falls.
  - Reset asserted mid-operation aborts immediately. No partial-pass recovery; INIT re-clears both RAMs.
- **States:** INIT_PEND, INIT, IDLE, SHIFT, FILTER, DRAIN, ERR, UPDATE, DONE.
- **INIT:** TAPS cycles. k = 0..TAPS-1.
  - x_addr = c_addr = k; x_we = c_we = c_zero = 1; x_wdata = 0.
  - Moves to IDLE after k = TAPS-1.
- **IDLE:** on `ready`=1, latch d_sample and x_sample, then go to SHIFT.
- **SHIFT:** 1 cycle.
  - head <= head-1 mod TAPS; x_addr = head-1 mod TAPS; x_we = 1; x_wdata = latched x; mac_clr = 1.
- **FILTER:** TAPS cycles, k = 0..TAPS-1.
  - x_addr = (head+k) mod TAPS, using the updated head.
  - c_addr = k; mac_en = 1; mac_sel = 0.
  - Tap 0 is the newest sample; wrap-around is by natural AW-bit overflow.
- **DRAIN:** MAC_LAT cycles with no strobes asserted.
- **ERR:** 1 cycle.
  - y = sat_DW(mac_result >>> (DW-1)).
  - e = sat_DW(d - y), saturating to [-2^(DW-1), 2^(DW-1)-1].
  - Latch out_sample = e and mu_err = e >>> MU_SHIFT.
  - Next state is UPDATE if adapt_en=1, else DONE.
- **UPDATE:** TAPS cycles, k = 0..TAPS-1.
  - x_addr = (head+k) mod TAPS; c_addr = k; mac_sel = 1; c_we = 1; mac_en = 1.
  - Read-modify-write latency is owned by the datapath. The address is held stable for the cycle.
- **DONE:** 1 cycle, out_valid = 1, then IDLE.
- **Latency from the edge that samples `ready` to the DONE edge:**
  - 2 + 2*TAPS + MAC_LAT = 36 cycles with defaults;
  - 2 + TAPS + MAC_LAT = 20 cycles when adapt_en=0.
- **Overrun:** `ready` in any state other than IDLE causes:
  - overrun = 1 for that cycle;
  - the sample is dropped and the latches are unchanged;
  - the current pass continues undisturbed.
- **Back-to-back:** `ready` in IDLE on the cycle right after DONE is accepted.
- **Strobe exclusivity:** x_we, c_we, mac_en and mac_clr are never asserted outside the states listed above.

Test Plan:
- **Reset/init:** pulse Reset for 3 cycles mid-UPDATE.
  - All outputs are 0 during reset.
  - Then exactly 16 INIT cycles with x_we = c_we = c_zero = 1, addresses 0..15.
  - busy = 1 throughout, then IDLE.
- **Address sequencing:** 18 consecutive samples with ready every 40 cycles.
  - Write addresses are 15, 14, ..., 0, 15, 14.
  - On the 17th sample, FILTER x_addr runs 15, 0, 1, ..., 14 (wrap).
  - out_valid arrives 36 edges after each ready.
- **Arithmetic with model MAC:** d = 0x50, mac_result = 0x2000 (y = 64).
  - out_sample = 0x10, mu_err = 0x01.
  - d = 0x80 with y = 127 gives out_sample = 0x80 (saturated −128).
- **adapt_en=0:** no c_we assertions outside INIT; out_valid 20 edges after ready; coefficient RAM unchanged.
- **Overrun:** ready asserted again 10 cycles into a pass with different d/x.
  - One-cycle overrun pulse; the first sample's result is unaffected; no extra out_valid.
- **Back-to-back:** ready on the cycle after out_valid is accepted with no overrun; the second out_valid follows 36 edges later.
